// File: rtl/axil_reg_pkg.sv
// Shared types and helpers for the AXI-lite to 32-bit register bridge.
package axil_reg_pkg;

    typedef enum logic [2:0] {Idle, WrBeat, RdBeat, WrResp, RdResp} state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Number of 32-bit register accesses needed for a beat of 2^size bytes.
    function automatic int unsigned num_chunks(input logic [2:0] size);
        return (size < 3'd2) ? 32'd1 : (32'd1 << (size - 3'd2));
    endfunction

endpackage

// File: rtl/axil_reg_chan_buf.sv
// One-entry valid/ready holding buffer; entry is released explicitly by the consumer.
module axil_reg_chan_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [Width-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             pop_i
);

    logic             full_q, full_d;
    logic [Width-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end else if (in_valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready_o  = !full_q;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/axil_reg_splitter.sv
// AXI-lite slave that splits each data beat into sequential 32-bit register accesses.
module axil_reg_splitter
    import axil_reg_pkg::*;
#(
    parameter int unsigned AxiDataWidth = 64,
    parameter logic [63:0] BaseAddr     = 64'he200000000,
    parameter logic [31:0] RegionSize   = 32'h0400_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [63:0]               s_awaddr,
    input  logic [2:0]                s_awsize,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [AxiDataWidth-1:0]   s_wdata,
    input  logic [AxiDataWidth/8-1:0] s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [63:0]               s_araddr,
    input  logic [2:0]                s_arsize,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [AxiDataWidth-1:0]   s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic                      reg_valid,
    output logic                      reg_write,
    output logic [31:0]               reg_addr,
    output logic [31:0]               reg_wdata,
    output logic [3:0]                reg_wstrb,
    input  logic                      reg_ready,
    input  logic [31:0]               reg_rdata,
    input  logic                      reg_error
);

    localparam int unsigned Lanes   = AxiDataWidth / 32;
    localparam int unsigned StrbW   = AxiDataWidth / 8;
    localparam int unsigned LaneW   = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned MaxSize = $clog2(StrbW);
    localparam int unsigned WBufW   = AxiDataWidth + StrbW;

    logic [34:0]      aw_buf_data, ar_buf_data;
    logic [WBufW-1:0] w_buf_data;
    logic             aw_full, w_full, ar_full;
    logic             aw_pop, w_pop, ar_pop;

    axil_reg_chan_buf #(.Width(35)) u_aw_buf (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  ({s_awaddr[31:0], s_awsize}),
        .in_valid_i (s_awvalid),
        .in_ready_o (s_awready),
        .out_data_o (aw_buf_data),
        .out_valid_o(aw_full),
        .pop_i      (aw_pop)
    );

    axil_reg_chan_buf #(.Width(WBufW)) u_w_buf (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  ({s_wdata, s_wstrb}),
        .in_valid_i (s_wvalid),
        .in_ready_o (s_wready),
        .out_data_o (w_buf_data),
        .out_valid_o(w_full),
        .pop_i      (w_pop)
    );

    axil_reg_chan_buf #(.Width(35)) u_ar_buf (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  ({s_araddr[31:0], s_arsize}),
        .in_valid_i (s_arvalid),
        .in_ready_o (s_arready),
        .out_data_o (ar_buf_data),
        .out_valid_o(ar_full),
        .pop_i      (ar_pop)
    );

    state_e                       state_q, state_d;
    logic [LaneW-1:0]             cnt_q, cnt_d;
    logic                         err_q, err_d;
    logic                         prefer_wr_q, prefer_wr_d;
    logic [Lanes-1:0][31:0]       rdata_q, rdata_d;

    logic [Lanes-1:0][31:0]       wdat_lanes;
    logic [Lanes-1:0][3:0]        strb_lanes;
    logic                         grant_wr, grant_rd, use_aw;
    logic [31:0]                  cur_addr, off, chunk_addr;
    logic [2:0]                   cur_size;
    int unsigned                  n_chunks;
    logic                         illegal, last, skip, beat;
    logic [LaneW-1:0]             lane;
    logic [3:0]                   cur_strb;

    assign wdat_lanes = w_buf_data[StrbW +: AxiDataWidth];
    assign strb_lanes = w_buf_data[StrbW-1:0];

    assign grant_wr = aw_full && w_full && (!ar_full || prefer_wr_q);
    assign grant_rd = ar_full && !grant_wr;

    // In Idle the decoded request is the one about to be granted; in a beat it is the active one.
    assign use_aw   = (state_q == Idle) ? grant_wr : (state_q == WrBeat);
    assign cur_addr = use_aw ? aw_buf_data[34:3] : ar_buf_data[34:3];
    assign cur_size = use_aw ? aw_buf_data[2:0]  : ar_buf_data[2:0];

    assign off        = {cur_addr[31:2], 2'b00} - BaseAddr[31:0];
    assign n_chunks   = num_chunks(cur_size);
    assign illegal    = (cur_size > 3'(MaxSize)) ||
                        (({2'b00, off} + 34'(4 * n_chunks)) > {2'b00, RegionSize});
    assign chunk_addr = off + 32'({cnt_q, 2'b00});
    assign lane       = (Lanes == 1) ? '0 : cur_addr[LaneW+1:2] + cnt_q;
    assign last       = (32'(cnt_q) + 32'd1) >= n_chunks;
    assign cur_strb   = strb_lanes[lane];
    assign beat       = (state_q == WrBeat) || (state_q == RdBeat);
    assign skip       = (state_q == WrBeat) && (cur_strb == 4'h0);

    always_comb begin
        reg_valid = (state_q == RdBeat) || ((state_q == WrBeat) && !skip);
        reg_write = (state_q == WrBeat);
        reg_addr  = beat ? chunk_addr : 32'h0;
        reg_wdata = (state_q == WrBeat) ? wdat_lanes[lane] : 32'h0;
        reg_wstrb = (state_q == WrBeat) ? cur_strb : 4'h0;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        prefer_wr_d = prefer_wr_q;
        rdata_d     = rdata_q;
        aw_pop      = 1'b0;
        w_pop       = 1'b0;
        ar_pop      = 1'b0;
        unique case (state_q)
            Idle: begin
                if (grant_wr || grant_rd) begin
                    cnt_d       = '0;
                    err_d       = illegal;
                    prefer_wr_d = grant_rd;
                    if (grant_rd) rdata_d = '0;
                    if (illegal) begin
                        state_d = grant_wr ? WrResp : RdResp;
                        aw_pop  = grant_wr;
                        w_pop   = grant_wr;
                        ar_pop  = grant_rd;
                    end else begin
                        state_d = grant_wr ? WrBeat : RdBeat;
                    end
                end
            end
            WrBeat, RdBeat: begin
                if (skip || reg_ready) begin
                    if (reg_valid && reg_error) err_d = 1'b1;
                    if (state_q == RdBeat) rdata_d[lane] = reg_rdata;
                    if (last) begin
                        state_d = (state_q == WrBeat) ? WrResp : RdResp;
                        aw_pop  = (state_q == WrBeat);
                        w_pop   = (state_q == WrBeat);
                        ar_pop  = (state_q == RdBeat);
                    end else begin
                        cnt_d = cnt_q + LaneW'(1);
                    end
                end
            end
            WrResp: if (s_bready) state_d = Idle;
            RdResp: if (s_rready) state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= Idle;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            prefer_wr_q <= 1'b1;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            prefer_wr_q <= prefer_wr_d;
            rdata_q     <= rdata_d;
        end
    end

    assign s_bvalid = (state_q == WrResp);
    assign s_rvalid = (state_q == RdResp);
    assign s_bresp  = (s_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_rresp  = (s_rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_rdata  = rdata_q;

    logic unused_bits;
    assign unused_bits = ^{s_awaddr[63:32], s_araddr[63:32], cur_addr[1:0]};

endmodule
